// File: rtl/pv_pkg.sv
// Shared width defaults for the phase vocoder front end.
// Keeps peak_phase_tracker and phase_vocoder in agreement.
package pv_pkg;

  localparam int PV_PHASE_WIDTH = 24;
  localparam int PV_PHASE_FRAC  = 21;
  localparam int PV_MAG_WIDTH   = 32;
  localparam int PV_K_WIDTH     = 11;
  localparam int PV_K_LO        = 1;
  localparam int PV_K_HI        = 1023;

endpackage

// File: rtl/peak_phase_tracker_if.sv
// Bin stream in, per-frame peak tuple out.
// master drives bins, slave produces the tuple.
interface peak_phase_tracker_if
  import pv_pkg::*;
#(
  parameter int PW = PV_PHASE_WIDTH,
  parameter int MW = PV_MAG_WIDTH,
  parameter int KW = PV_K_WIDTH
);

  logic [MW-1:0]        bin_mag;
  logic signed [PW-1:0] bin_phase;
  logic                 bin_valid;
  logic                 bin_last;

  logic signed [PW-1:0] phase;
  logic signed [PW-1:0] last_phase;
  logic                 phases_valid;
  logic [KW-1:0]        k_max;
  logic                 k_max_valid;
  logic                 frame_error;

  modport master (
    output bin_mag, bin_phase, bin_valid, bin_last,
    input  phase, last_phase, phases_valid,
    input  k_max, k_max_valid, frame_error
  );

  modport slave (
    input  bin_mag, bin_phase, bin_valid, bin_last,
    output phase, last_phase, phases_valid,
    output k_max, k_max_valid, frame_error
  );

endinterface

// File: rtl/phase_history_ram.sv
// Single-port read-first phase history, one-cycle read.
// No reset so it maps onto block RAM.
module phase_history_ram #(
  parameter int AW = 11,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q    <= mem_q[addr];
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/peak_phase_tracker.sv
// Finds the in-band peak bin per frame and pairs its
// phase with the previous frame's phase at that bin.
module peak_phase_tracker
  import pv_pkg::*;
#(
  parameter int PHASE_WIDTH = PV_PHASE_WIDTH,
  parameter int MAG_WIDTH   = PV_MAG_WIDTH,
  parameter int K_WIDTH     = PV_K_WIDTH,
  parameter int K_LO        = PV_K_LO,
  parameter int K_HI        = PV_K_HI
) (
  input logic clock,
  input logic reset_n,
  peak_phase_tracker_if.slave bus
);

  localparam logic [K_WIDTH-1:0] K_END  = '1;
  localparam logic [K_WIDTH-1:0] K_LO_V = K_WIDTH'(K_LO);
  localparam logic [K_WIDTH-1:0] K_HI_V = K_WIDTH'(K_HI);

  logic [K_WIDTH-1:0]     k_q, k_d;
  logic                   ovf_q, ovf_d;

  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_last_q, s1_last_d;
  logic                   s1_err_q, s1_err_d;
  logic                   s1_first_q, s1_first_d;
  logic [K_WIDTH-1:0]     s1_k_q, s1_k_d;
  logic [MAG_WIDTH-1:0]   s1_mag_q, s1_mag_d;
  logic [PHASE_WIDTH-1:0] s1_phase_q, s1_phase_d;
  logic [PHASE_WIDTH-1:0] ram_rdata;

  logic                   s2_last_q, s2_last_d;
  logic                   s2_err_q, s2_err_d;
  logic [MAG_WIDTH-1:0]   best_mag_q, best_mag_d;
  logic [K_WIDTH-1:0]     best_k_q, best_k_d;
  logic [PHASE_WIDTH-1:0] best_phase_q, best_phase_d;
  logic [PHASE_WIDTH-1:0] best_last_q, best_last_d;

  logic                   hist_ok_q, hist_ok_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [PHASE_WIDTH-1:0] last_phase_q, last_phase_d;
  logic [K_WIDTH-1:0]     k_max_q, k_max_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  logic [MAG_WIDTH-1:0]   base_mag;
  logic                   in_band;
  logic                   take;

  phase_history_ram #(
    .AW (K_WIDTH),
    .DW (PHASE_WIDTH)
  ) u_ram (
    .clk   (clock),
    .en    (bus.bin_valid),
    .addr  (k_q),
    .wdata (bus.bin_phase),
    .rdata (ram_rdata)
  );

  always_comb begin
    k_d        = k_q;
    ovf_d      = ovf_q;
    s1_valid_d = bus.bin_valid;
    s1_last_d  = bus.bin_valid & bus.bin_last;
    s1_err_d   = bus.bin_valid & bus.bin_last &
                 (ovf_q | (k_q != K_END));
    s1_first_d = (k_q == '0) & ~ovf_q;
    s1_k_d     = k_q;
    s1_mag_d   = bus.bin_mag;
    s1_phase_d = bus.bin_phase;
    if (bus.bin_valid) begin
      if (bus.bin_last) begin
        k_d   = '0;
        ovf_d = 1'b0;
      end else begin
        k_d = k_q + 1'b1;
        if (k_q == K_END) ovf_d = 1'b1;
      end
    end
  end

  // K_LO always captures so an all-zero band still has phases
  always_comb begin
    base_mag = s1_first_q ? '0 : best_mag_q;
    in_band  = (s1_k_q >= K_LO_V) && (s1_k_q <= K_HI_V);
    take     = s1_valid_q & in_band &
               ((s1_mag_q > base_mag) | (s1_k_q == K_LO_V));
    best_mag_d   = best_mag_q;
    best_k_d     = best_k_q;
    best_phase_d = best_phase_q;
    best_last_d  = best_last_q;
    if (s1_valid_q && s1_first_q) begin
      best_mag_d = '0;
      best_k_d   = K_LO_V;
    end
    if (take) begin
      best_mag_d   = s1_mag_q;
      best_k_d     = s1_k_q;
      best_phase_d = s1_phase_q;
      best_last_d  = ram_rdata;
    end
    s2_last_d = s1_valid_q & s1_last_q;
    s2_err_d  = s1_valid_q & s1_err_q;
  end

  always_comb begin
    hist_ok_d    = hist_ok_q;
    phase_d      = phase_q;
    last_phase_d = last_phase_q;
    k_max_d      = k_max_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    if (s2_last_q) begin
      hist_ok_d = ~s2_err_q;
      if (s2_err_q) begin
        err_d = 1'b1;
      end else if (hist_ok_q) begin
        valid_d      = 1'b1;
        phase_d      = best_phase_q;
        last_phase_d = best_last_q;
        k_max_d      = best_k_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k_q          <= '0;
      ovf_q        <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_err_q     <= 1'b0;
      s1_first_q   <= 1'b0;
      s1_k_q       <= '0;
      s1_mag_q     <= '0;
      s1_phase_q   <= '0;
      s2_last_q    <= 1'b0;
      s2_err_q     <= 1'b0;
      best_mag_q   <= '0;
      best_k_q     <= '0;
      best_phase_q <= '0;
      best_last_q  <= '0;
      hist_ok_q    <= 1'b0;
      phase_q      <= '0;
      last_phase_q <= '0;
      k_max_q      <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      k_q          <= k_d;
      ovf_q        <= ovf_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      s1_err_q     <= s1_err_d;
      s1_first_q   <= s1_first_d;
      s1_k_q       <= s1_k_d;
      s1_mag_q     <= s1_mag_d;
      s1_phase_q   <= s1_phase_d;
      s2_last_q    <= s2_last_d;
      s2_err_q     <= s2_err_d;
      best_mag_q   <= best_mag_d;
      best_k_q     <= best_k_d;
      best_phase_q <= best_phase_d;
      best_last_q  <= best_last_d;
      hist_ok_q    <= hist_ok_d;
      phase_q      <= phase_d;
      last_phase_q <= last_phase_d;
      k_max_q      <= k_max_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign bus.phase        = phase_q;
  assign bus.last_phase   = last_phase_q;
  assign bus.k_max        = k_max_q;
  assign bus.phases_valid = valid_q;
  assign bus.k_max_valid  = valid_q;
  assign bus.frame_error  = err_q;

endmodule

// File: tb/tb_peak_phase_tracker.sv
// Random frames vs a frame-level reference model;
// expected pulses queued at issue, checked by a monitor.
module tb_peak_phase_tracker;
  import pv_pkg::*;

  localparam int PW   = 24;
  localparam int MW   = 32;
  localparam int KW   = 11;
  localparam int NB   = 1 << KW;
  localparam int K_LO = 1;
  localparam int K_HI = 1023;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  peak_phase_tracker_if #(.PW(PW), .MW(MW), .KW(KW)) bus();

  peak_phase_tracker #(
    .PHASE_WIDTH (PW),
    .MAG_WIDTH   (MW),
    .K_WIDTH     (KW),
    .K_LO        (K_LO),
    .K_HI        (K_HI)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    bit          is_err;
    int          k;
    logic [PW-1:0] ph;
    logic [PW-1:0] lph;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  logic [MW-1:0] fm [4096];
  logic [PW-1:0] fp [4096];
  logic [PW-1:0] prev_ph [NB];
  bit            m_hist;
  int            o_k;
  logic [PW-1:0] o_ph;
  logic [PW-1:0] o_lph;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, req);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_phase"}, 64'($unsigned(bus.phase)), 0);
    chk({tag, "_last_phase"},
        64'($unsigned(bus.last_phase)), 0);
    chk({tag, "_k_max"}, 64'(bus.k_max), 0);
    chk({tag, "_phases_valid"}, 64'(bus.phases_valid), 0);
    chk({tag, "_k_max_valid"}, 64'(bus.k_max_valid), 0);
    chk({tag, "_frame_error"}, 64'(bus.frame_error), 0);
  endtask

  task automatic model_reset();
    m_hist = 0;
    o_k    = 0;
    o_ph   = '0;
    o_lph  = '0;
  endtask

  // frame-level reference: length check, argmax, history
  task automatic model_frame(input int len, input int dc);
    exp_t e;
    int   best;
    if (len != NB) begin
      e = '{1'b1, o_k, o_ph, o_lph, dc + 3};
      sb.push_back(e);
      m_hist = 0;
    end else begin
      if (m_hist) begin
        best = K_LO;
        for (int k = K_LO + 1; k <= K_HI; k++)
          if (fm[k] > fm[best]) best = k;
        o_k   = best;
        o_ph  = fp[best];
        o_lph = prev_ph[best];
        e = '{1'b0, o_k, o_ph, o_lph, dc + 3};
        sb.push_back(e);
      end
      m_hist = 1;
      for (int k = 0; k < NB; k++) prev_ph[k] = fp[k];
    end
  endtask

  task automatic beat(input logic [MW-1:0] m,
                      input logic [PW-1:0] p,
                      input bit last);
    @(posedge clock);
    #1;
    bus.bin_valid = 1'b1;
    bus.bin_mag   = m;
    bus.bin_phase = p;
    bus.bin_last  = last;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      bus.bin_valid = 1'b0;
      bus.bin_last  = 1'b0;
      bus.bin_mag   = $urandom;
      bus.bin_phase = PW'($urandom);
    end
  endtask

  task automatic send_frame(input int len,
                            input int gmax,
                            input bit keep);
    int dc;
    dc = 0;
    for (int i = 0; i < len; i++) begin
      if (i > 0 && gmax > 0) idle($urandom_range(gmax, 0));
      beat(fm[i], fp[i], i == len - 1);
      if (i == len - 1) dc = cyc;
    end
    model_frame(len, dc);
    if (!keep) idle(1);
  endtask

  task automatic fill_rand(input int mmax);
    for (int i = 0; i < 4096; i++) begin
      fm[i] = MW'($urandom_range(mmax, 0));
      fp[i] = PW'($urandom);
    end
  endtask

  initial begin
    exp_t e;
    bit   pulse;
    forever begin
      @(posedge clock);
      #1;
      pulse = bus.phases_valid || bus.frame_error;
      if (pulse && sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: pv=%0b fe=%0b cyc=%0d, expected none",
                 bus.phases_valid, bus.frame_error, cyc);
      end else if (pulse) begin
        e = sb.pop_front();
        chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
        chk("frame_error", 64'(bus.frame_error), 64'(e.is_err));
        chk("phases_valid", 64'(bus.phases_valid),
            64'(!e.is_err));
        chk("k_max_valid", 64'(bus.k_max_valid),
            64'(!e.is_err));
        chk("k_max", 64'(bus.k_max), 64'(e.k));
        chk("phase", 64'($unsigned(bus.phase)), 64'(e.ph));
        chk("last_phase", 64'($unsigned(bus.last_phase)),
            64'(e.lph));
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_pulse: no pulse at expected cyc %0d",
                 e.cyc);
      end
    end
  end

  initial begin
    bus.bin_valid = 1'b0;
    bus.bin_last  = 1'b0;
    bus.bin_mag   = '0;
    bus.bin_phase = '0;
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_zero("por");
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 4096; i++) begin
      fm[i] = 32'h10;
      fp[i] = PW'($urandom);
    end
    fm[100] = 32'h1000;
    fp[100] = 24'h080000;
    send_frame(NB, 0, 0);
    for (int i = 0; i < 4096; i++) fp[i] = PW'($urandom);
    fp[100] = 24'h100000;
    send_frame(NB, 0, 0);

    fill_rand(256);
    fm[50] = 32'h2000;
    fm[60] = 32'h2000;
    send_frame(NB, 0, 0);

    fill_rand(256);
    fm[0]    = 32'hFFFF;
    fm[1500] = 32'hF000;
    fm[1024] = 32'hF000;
    fm[300]  = 32'h0800;
    send_frame(NB, 0, 0);

    fill_rand(1000);
    send_frame(1000, 0, 0);
    fill_rand(1000);
    send_frame(NB, 0, 0);
    fill_rand(1000);
    send_frame(NB, 0, 0);

    fill_rand(1000);
    send_frame(NB + 10, 0, 0);
    fill_rand(1000);
    send_frame(NB, 0, 0);
    fill_rand(1000);
    send_frame(NB, 0, 0);

    fill_rand(0);
    fm[0]    = 32'h5;
    fm[1500] = 32'h7;
    send_frame(NB, 0, 0);

    fill_rand(255);
    for (int i = 0; i < 500; i++) beat(fm[i], fp[i], 1'b0);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    bus.bin_valid = 1'b0;
    bus.bin_last  = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    fill_rand(4000);
    send_frame(NB, 0, 0);
    fill_rand(4000);
    send_frame(NB, 0, 0);

    fill_rand(300);
    send_frame(NB, 5, 1);
    fill_rand(300);
    send_frame(NB, 0, 1);
    fill_rand(65535);
    send_frame(NB, 0, 0);

    idle(10);
    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
